// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared widths and the hex-to-segment table for the scan controller.
// Segment bits are {g,f,e,d,c,b,a}, active-high.
package seg_scan_pkg;
    localparam int NIBBLE_W = 4;
    localparam int SEG_W    = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F = 7'h71;

    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };
endpackage

// File: rtl/seg7_hex_dec.sv
// seg7_hex_dec: combinational nibble to 7-segment pattern (0-9, A-F).
module seg7_hex_dec
    import seg_scan_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nib_i,
    output logic [SEG_W-1:0]    seg_o
);
    assign seg_o = SEG_TABLE[nib_i];
endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed N-digit 7-segment scanner with double-buffered input,
// leading-zero blanking, per-digit blink, brightness PWM and anti-ghost dead time.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_W      = 18,
    parameter int BLANK_CYC  = 64,
    parameter int BLINK_W    = 24
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] din,
    input  logic                           din_valid,
    output logic                           din_ready,
    input  logic [NUM_DIGITS-1:0]          dp_in,
    input  logic [NUM_DIGITS-1:0]          blink_en,
    input  logic                           lz_blank_en,
    input  logic [3:0]                     bright,
    output logic [NUM_DIGITS-1:0]          an,
    output logic [SEG_W-1:0]               seg,
    output logic                           dp,
    output logic                           frame_start
);
    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam int BUF_W = NIBBLE_W * NUM_DIGITS;

    logic [DIV_W-1:0]      div_q, div_d;
    logic [SEL_W-1:0]      idx_q, idx_d;
    logic [BLINK_W-1:0]    blink_q, blink_d;
    logic [BUF_W-1:0]      act_din_q, act_din_d, sh_din_q, sh_din_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
    logic                  pend_q, pend_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d, fs_q, fs_d;

    logic                  tick, wrap, accept, blank;
    logic [NIBBLE_W-1:0]   nib;
    logic [SEG_W-1:0]      dec_seg;
    logic [NUM_DIGITS-1:0] lz_top;

    seg7_hex_dec u_dec (
        .nib_i (nib),
        .seg_o (dec_seg)
    );

    always_comb begin
        tick      = &div_q;
        wrap      = tick && (idx_q == SEL_W'(NUM_DIGITS - 1));
        accept    = din_valid && !pend_q;
        div_d     = div_q + 1'b1;
        blink_d   = blink_q + 1'b1;
        idx_d     = wrap ? '0 : (tick ? idx_q + 1'b1 : idx_q);
        sh_din_d  = accept ? din : sh_din_q;
        sh_dp_d   = accept ? dp_in : sh_dp_q;
        pend_d    = accept ? 1'b1 : (wrap ? 1'b0 : pend_q);
        // shadow moves to active only on the frame wrap, so a frame never mixes two words
        act_din_d = (wrap && pend_q) ? sh_din_q : act_din_q;
        act_dp_d  = (wrap && pend_q) ? sh_dp_q : act_dp_q;
    end

    always_comb begin
        nib = act_din_q[NIBBLE_W*idx_q +: NIBBLE_W];
        for (int i = 0; i < NUM_DIGITS; i++)
            lz_top[i] = (act_din_q >> (NIBBLE_W * i)) == '0;
        blank = (div_q < DIV_W'(BLANK_CYC))
             || (div_q[DIV_W-1 -: 4] > bright)
             || (blink_en[idx_q] && blink_q[BLINK_W-1])
             || (lz_blank_en && idx_q != '0 && lz_top[idx_q]);
        an_d  = blank ? '0 : NUM_DIGITS'(1) << idx_q;
        seg_d = blank ? SEG_BLANK : dec_seg;
        dp_d  = !blank && act_dp_q[idx_q];
        fs_d  = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            idx_q     <= '0;
            blink_q   <= '0;
            act_din_q <= '0;
            act_dp_q  <= '0;
            sh_din_q  <= '0;
            sh_dp_q   <= '0;
            pend_q    <= 1'b0;
            an_q      <= '0;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            blink_q   <= blink_d;
            act_din_q <= act_din_d;
            act_dp_q  <= act_dp_d;
            sh_din_q  <= sh_din_d;
            sh_dp_q   <= sh_dp_d;
            pend_q    <= pend_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            fs_q      <= fs_d;
        end
    end

    assign din_ready   = !pend_q;
    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: scoreboard bench; each frame start pushes the digits expected to light,
// a monitor pops one entry per lit dwell and checks anode, segments, dp and dwell length.
module tb_seg_scan_mux;
    localparam int ND = 6;

    typedef struct {
        logic [ND-1:0] an;
        logic [6:0]    seg;
        logic          dp;
        int            len;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [23:0]   din;
    logic          din_valid;
    logic          din_ready;
    logic [ND-1:0] dp_in, blink_en, an;
    logic          lz_blank_en, dp, frame_start;
    logic [3:0]    bright;
    logic [6:0]    seg;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    exp_t q[$];
    int tests = 0, fails = 0;
    int n;
    int prev_n0;
    logic [23:0]   m_act, m_sh;
    logic [ND-1:0] m_adp, m_sdp;
    logic          m_pend, stop_push;
    logic [3:0]    nxt_bright;
    logic          nxt_lz;
    logic [ND-1:0] nxt_blink;
    logic [ND-1:0] prev_an;
    int            run, cur_len;
    logic          has_len;

    seg_scan_mux #(.NUM_DIGITS(ND), .DIV_W(6), .BLANK_CYC(4), .BLINK_W(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dp_in       (dp_in),
        .blink_en    (blink_en),
        .lz_blank_en (lz_blank_en),
        .bright      (bright),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // n equals the DUT's internal cycle count since reset release (div, blink, idx all derive from it)
    always @(posedge clk or negedge rst_n)
        if (!rst_n) n <= 0;
        else n <= n + 1;

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(int n0);
        exp_t e;
        int len;
        logic lit;
        if (prev_n0 >= 0) chk("frame_period", n0 - prev_n0, 384);
        prev_n0 = n0;
        bright = nxt_bright;
        lz_blank_en = nxt_lz;
        blink_en = nxt_blink;
        if (m_pend) begin
            m_act = m_sh;
            m_adp = m_sdp;
            m_pend = 1'b0;
        end
        if (stop_push) return;
        len = 4 * int'(bright);
        for (int d = 0; d < ND; d++) begin
            lit = len > 0;
            if (blink_en[d] && ((n0 + 64 * d) % 1024) >= 512) lit = 1'b0;
            if (lz_blank_en && d != 0 && (m_act >> (4 * d)) == 24'h0) lit = 1'b0;
            if (lit) begin
                e.an = ND'(1) << d;
                e.seg = seg_tab[m_act[4*d +: 4]];
                e.dp = m_adp[d];
                e.len = len;
                q.push_back(e);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (rst_n && frame_start) push_frame(n);
    endtask

    task automatic wait_frames(int k);
        int seen = 0, guard = 0;
        while (seen < k && guard < 1000 * k) begin
            step();
            guard++;
            if (frame_start) seen++;
        end
        chk("frame_timeout", seen, k);
    endtask

    task automatic send(logic [23:0] w, logic [ND-1:0] d, output int waited);
        din = w;
        dp_in = d;
        din_valid = 1'b1;
        waited = 0;
        while (!din_ready && waited < 1000) begin
            step();
            waited++;
        end
        step();
        din_valid = 1'b0;
        m_sh = w;
        m_sdp = d;
        m_pend = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_an = '0;
            run = 0;
            has_len = 1'b0;
        end else begin
            chk("an_onehot0", int'($onehot0(an)), 1);
            if (an == '0) chk("dark_seg_dp", int'({seg, dp}), 0);
            if (an != prev_an) begin
                if (prev_an != '0 && has_len) chk("dwell_len", run, cur_len);
                has_len = 1'b0;
                if (an != '0) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_lit: got an=%b seg=%h, expected dark", an, seg);
                    end else begin
                        e = q.pop_front();
                        chk("an", int'(an), int'(e.an));
                        chk("seg", int'(seg), int'(e.seg));
                        chk("dp", int'(dp), int'(e.dp));
                        cur_len = e.len;
                        has_len = 1'b1;
                    end
                    run = 1;
                end
            end else if (an != '0) begin
                run++;
            end
            prev_an = an;
        end
    end

    initial begin
        int w;
        rst_n = 1'b0;
        din = '0;
        din_valid = 1'b0;
        dp_in = '0;
        blink_en = '0;
        lz_blank_en = 1'b0;
        bright = 4'd15;
        nxt_bright = 4'd15;
        nxt_lz = 1'b0;
        nxt_blink = '0;
        prev_n0 = -1;
        m_act = '0; m_sh = '0; m_adp = '0; m_sdp = '0; m_pend = 1'b0;
        stop_push = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an", int'(an), 0);
        chk("rst_seg", int'(seg), 0);
        chk("rst_dp", int'(dp), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_ready", int'(din_ready), 1);
        rst_n = 1'b1;
        push_frame(0);
        send(24'h123456, 6'b000010, w);
        chk("first_accept_wait", w, 0);
        chk("ready_low_pending", int'(din_ready), 0);
        wait_frames(2);
        send(24'hABCDEF, 6'b100001, w);
        chk("a_accept_wait", w, 0);
        chk("ready_low_a", int'(din_ready), 0);
        send(24'h908070, 6'b000000, w);
        chk("b_held_cycles", w, 383);
        wait_frames(2);
        send(24'h000120, 6'b000000, w);
        chk("lz_accept_wait", w, 0);
        nxt_lz = 1'b1;
        wait_frames(3);
        nxt_lz = 1'b0;
        wait_frames(1);
        nxt_bright = 4'd7;
        wait_frames(1);
        nxt_bright = 4'd3;
        wait_frames(1);
        nxt_bright = 4'd0;
        wait_frames(1);
        nxt_bright = 4'd15;
        wait_frames(1);
        nxt_blink = 6'b000100;
        wait_frames(4);
        nxt_blink = '0;
        wait_frames(1);
        send(24'h777777, 6'b111111, w);
        chk("c_accept_wait", w, 0);
        repeat (100) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_an", int'(an), 0);
        chk("midrst_seg", int'(seg), 0);
        chk("midrst_dp", int'(dp), 0);
        chk("midrst_ready", int'(din_ready), 1);
        q.delete();
        m_act = '0; m_adp = '0; m_pend = 1'b0;
        prev_n0 = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_frame(0);
        chk("post_rst_ready", int'(din_ready), 1);
        wait_frames(2);
        stop_push = 1'b1;
        wait_frames(1);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
